// File: rtl/imem_rom_server.sv
// Instruction-memory responder: word-addressed ROM with a load port, a
// LATENCY-deep read delay line and an in-order response FIFO.
module imem_rom_server #(
  parameter int          DEPTH_WORDS     = 256,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] FILL_WORD       = 32'h0000_0013,
  parameter logic [31:0] ERR_DATA        = 32'h0000_0013,
  localparam int         AW              = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_data,
  output logic          resp_err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [3:0]    outstanding
);

  localparam int            PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int            FD       = 1 << PW;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [3:0]    MAX_CNT  = 4'(MAX_OUTSTANDING);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Array contents survive reset; only the power-up image is FILL_WORD.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: FILL_WORD};

  logic          accept, retire;
  logic          acc_err;
  logic [31:0]   acc_data;
  logic          push, push_err;
  logic [31:0]   push_data;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    fifo_cnt_q, fifo_cnt_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic [31:0]   fifo_data_q [FD];
  logic [FD-1:0] fifo_err_q;

  assign resp_valid  = (fifo_cnt_q != 4'd0);
  assign resp_data   = resp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_err    = resp_valid && fifo_err_q[rd_ptr_q];
  assign retire      = resp_valid && resp_ready;
  assign req_ready   = reset_n && ((outstanding_q < MAX_CNT) || retire);
  assign accept      = req_valid && req_ready;
  assign outstanding = outstanding_q;

  // Stage 0: address check and array read at the accept edge (read before write).
  assign acc_err  = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
  assign acc_data = acc_err ? ERR_DATA : mem_q[req_addr[AW+1:2]];

  always_ff @(posedge clk) begin
    if (load_en && reset_n) mem_q[load_addr] <= load_data;
  end

  // Delay line: an accepted entry reaches the FIFO LATENCY-1 edges later.
  if (LATENCY == 1) begin : g_direct
    assign push      = accept;
    assign push_err  = acc_err;
    assign push_data = acc_data;
  end else begin : g_pipe
    localparam int D = LATENCY - 1;
    logic [D-1:0] vld_q, vld_d;
    logic [D-1:0] err_q;
    logic [31:0]  data_q [D];

    always_comb begin
      vld_d    = '0;
      vld_d[0] = accept;
      for (int i = 1; i < D; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_q <= '0;
      else          vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      data_q[0] <= acc_data;
      err_q[0]  <= acc_err;
      for (int i = 1; i < D; i++) begin
        data_q[i] <= data_q[i-1];
        err_q[i]  <= err_q[i-1];
      end
    end

    assign push      = vld_q[D-1];
    assign push_err  = err_q[D-1];
    assign push_data = data_q[D-1];
  end

  // Response FIFO: outstanding bounds occupancy, so a push never finds it full.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    outstanding_d = outstanding_q;
    if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
    if (retire) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, retire})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 4'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 4'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({accept, retire})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= push_err;
    end
  end

endmodule

// File: tb/tb_imem_rom_server.sv
// Directed bench: instance a (LATENCY=1, MAX_OUTSTANDING=2) and instance b
// (LATENCY=3, MAX_OUTSTANDING=4) share clock, reset, request address and load port.
module tb_imem_rom_server;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   req_addr;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, resp_err_a;
  logic [31:0] resp_data_a;
  logic [3:0]  outstanding_a;
  logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_err_b;
  logic [31:0] resp_data_b;
  logic [3:0]  outstanding_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_rom_server #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
    .resp_data(resp_data_a), .resp_err(resp_err_a),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .outstanding(outstanding_a)
  );

  imem_rom_server #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .MAX_OUTSTANDING(4)) u_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_data(resp_data_b), .resp_err(resp_err_b),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .outstanding(outstanding_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    req_addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid_a = 1'b0; resp_ready_a = 1'b1;
    req_valid_b = 1'b0; resp_ready_b = 1'b1;

    // Reset state, plus a load that must be ignored while in reset.
    #1;
    chk("rst_req_ready_a", 32'(req_ready_a), 32'd0);
    chk("rst_resp_valid_a", 32'(resp_valid_a), 32'd0);
    chk("rst_resp_data_a", resp_data_a, 32'd0);
    chk("rst_resp_err_a", 32'(resp_err_a), 32'd0);
    chk("rst_outstanding_a", 32'(outstanding_a), 32'd0);
    chk("rst_req_ready_b", 32'(req_ready_b), 32'd0);
    load_en = 1'b1; load_addr = 4'd1; load_data = 32'hBAD0_BAD0;
    tick(); tick();
    load_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    load(4'd0, 32'h0050_0093);
    load(4'd2, 32'h0020_81B3);
    load(4'd3, 32'h1111_1111);

    // LATENCY=1 single fetch; word 1 still holds the fill value.
    resp_ready_a = 1'b1; req_addr = 32'h4; req_valid_a = 1'b1;
    #1 chk("a_ready_idle", 32'(req_ready_a), 32'd1);
    tick();
    req_valid_a = 1'b0;
    chk("a_lat1_valid", 32'(resp_valid_a), 32'd1);
    chk("a_load_in_reset_ignored", resp_data_a, 32'h0000_0013);
    chk("a_lat1_err", 32'(resp_err_a), 32'd0);
    chk("a_lat1_outstanding", 32'(outstanding_a), 32'd1);
    tick();
    chk("a_retired_valid", 32'(resp_valid_a), 32'd0);
    chk("a_retired_outstanding", 32'(outstanding_a), 32'd0);
    load(4'd1, 32'h0070_0113);

    // Backpressure: two accepts fill the window, then hold, then accept+retire.
    resp_ready_a = 1'b0; req_addr = 32'h0; req_valid_a = 1'b1;
    tick();
    req_addr = 32'h8;
    #1 chk("a_bp_ready1", 32'(req_ready_a), 32'd1);
    chk("a_bp_outst1", 32'(outstanding_a), 32'd1);
    tick();
    chk("a_bp_outst2", 32'(outstanding_a), 32'd2);
    chk("a_bp_ready_full", 32'(req_ready_a), 32'd0);
    chk("a_bp_valid", 32'(resp_valid_a), 32'd1);
    chk("a_bp_data", resp_data_a, 32'h0050_0093);
    tick();
    chk("a_hold_data", resp_data_a, 32'h0050_0093);
    chk("a_hold_outst", 32'(outstanding_a), 32'd2);
    resp_ready_a = 1'b1; req_addr = 32'hC;
    #1 chk("a_full_ready_on_retire", 32'(req_ready_a), 32'd1);
    tick();
    req_valid_a = 1'b0;
    chk("a_swap_outst", 32'(outstanding_a), 32'd2);
    chk("a_swap_data", resp_data_a, 32'h0020_81B3);
    tick();
    chk("a_drain_outst", 32'(outstanding_a), 32'd1);
    chk("a_drain_data", resp_data_a, 32'h1111_1111);
    tick();
    chk("a_empty_valid", 32'(resp_valid_a), 32'd0);
    chk("a_empty_outst", 32'(outstanding_a), 32'd0);

    // Error responses, back to back: misaligned, out of range, last word, word 0.
    req_valid_a = 1'b1; req_addr = 32'h2;
    tick();
    req_addr = 32'd64;
    chk("a_misalign_err", 32'(resp_err_a), 32'd1);
    chk("a_misalign_data", resp_data_a, 32'h0000_0013);
    tick();
    req_addr = 32'd60;
    chk("a_range_err", 32'(resp_err_a), 32'd1);
    chk("a_range_data", resp_data_a, 32'h0000_0013);
    tick();
    req_addr = 32'h0;
    chk("a_lastword_err", 32'(resp_err_a), 32'd0);
    chk("a_lastword_valid", 32'(resp_valid_a), 32'd1);
    tick();
    req_valid_a = 1'b0;
    chk("a_after_err_err", 32'(resp_err_a), 32'd0);
    chk("a_after_err_data", resp_data_a, 32'h0050_0093);
    tick();
    chk("a_err_drained", 32'(resp_valid_a), 32'd0);

    // Load and fetch of the same word on one edge returns the old word.
    load_en = 1'b1; load_addr = 4'd5; load_data = 32'hDEAD_BEEF;
    req_addr = 32'h14; req_valid_a = 1'b1;
    tick();
    load_en = 1'b0;
    chk("a_rbw_old", resp_data_a, 32'h0000_0013);
    tick();
    req_valid_a = 1'b0;
    chk("a_rbw_new", resp_data_a, 32'hDEAD_BEEF);
    tick();

    // LATENCY=3 streaming: first response after the third edge, then one per cycle.
    resp_ready_b = 1'b1; req_valid_b = 1'b1; req_addr = 32'h0;
    tick();
    chk("b_lat_e1_valid", 32'(resp_valid_b), 32'd0);
    req_addr = 32'h4;
    tick();
    chk("b_lat_e2_valid", 32'(resp_valid_b), 32'd0);
    req_addr = 32'h8;
    tick();
    chk("b_lat_e3_valid", 32'(resp_valid_b), 32'd1);
    chk("b_stream_w0", resp_data_b, 32'h0050_0093);
    chk("b_stream_outst3", 32'(outstanding_b), 32'd3);
    req_addr = 32'hC;
    tick();
    req_valid_b = 1'b0;
    chk("b_stream_w1", resp_data_b, 32'h0070_0113);
    chk("b_stream_outst_swap", 32'(outstanding_b), 32'd3);
    tick();
    chk("b_stream_w2", resp_data_b, 32'h0020_81B3);
    tick();
    chk("b_stream_w3", resp_data_b, 32'h1111_1111);
    tick();
    chk("b_stream_done_valid", 32'(resp_valid_b), 32'd0);
    chk("b_stream_done_outst", 32'(outstanding_b), 32'd0);

    // Asynchronous reset mid-cycle with three requests in flight.
    resp_ready_b = 1'b0; req_valid_b = 1'b1; req_addr = 32'h8;
    tick(); tick(); tick();
    req_valid_b = 1'b0;
    chk("b_inflight_outst", 32'(outstanding_b), 32'd3);
    chk("b_inflight_valid", 32'(resp_valid_b), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("b_async_valid", 32'(resp_valid_b), 32'd0);
    chk("b_async_ready", 32'(req_ready_b), 32'd0);
    chk("b_async_outst", 32'(outstanding_b), 32'd0);
    chk("b_async_data", resp_data_b, 32'd0);
    tick(); tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    resp_ready_b = 1'b1; req_addr = 32'h0; req_valid_b = 1'b1;
    tick();
    req_valid_b = 1'b0;
    chk("b_post_rst_no_stale1", 32'(resp_valid_b), 32'd0);
    tick();
    chk("b_post_rst_no_stale2", 32'(resp_valid_b), 32'd0);
    tick();
    chk("b_post_rst_valid", 32'(resp_valid_b), 32'd1);
    chk("b_post_rst_data", resp_data_b, 32'h0050_0093);
    chk("b_post_rst_err", 32'(resp_err_b), 32'd0);
    tick();
    chk("b_post_rst_drained", 32'(resp_valid_b), 32'd0);
    chk("b_post_rst_outst", 32'(outstanding_b), 32'd0);
    tick(); tick();
    chk("b_no_late_stale", 32'(resp_valid_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imem_rom_server.md
Name: imem_rom_server

Overview:
- Parametrised instruction-memory responder on the imem_if request/response channel; replaces the single-outstanding fixed-latency fetch model.
- Sits between cpu_top's fetch port and a word-addressed ROM array. Supports a configurable read latency and multiple outstanding requests with in-order responses.
- Provides a load port for writing program words before or during a run, and an error flag for misaligned or out-of-range fetches.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, at least 4.
- LATENCY, 1, cycles from request acceptance to earliest resp_valid; range 1..8.
- MAX_OUTSTANDING, 2, accepted-but-unretired requests allowed; range 1..8.
- FILL_WORD, 32'h00000013, time-zero contents of every word (NOP).
- ERR_DATA, 32'h00000013, resp_data returned with resp_err.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  server can accept a request
- req_addr  in  32  byte address
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_data  out  32  instruction word
- resp_err  out  1  response is for a misaligned or out-of-range address
- load_en  in  1  write one word
- load_addr  in  log2(DEPTH_WORDS)  word index
- load_data  in  32  word to write
- outstanding  out  4  accepted-but-unretired count (debug)

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset_n=0: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, outstanding=0. All pipeline stages and the response FIFO are emptied, and requests in flight are discarded.
- Reset does not change array contents. The array holds FILL_WORD from time zero.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = (outstanding < MAX_OUTSTANDING), or (outstanding == MAX_OUTSTANDING && resp_valid && resp_ready). Accept and retire may happen on the same edge.
- Address check at acceptance:
  - err = (req_addr[1:0] != 0) || (req_addr[31:2] >= DEPTH_WORDS).
  - Without err: data = array[req_addr[log2(DEPTH_WORDS)+1:2]], read at the accept edge.
  - With err: data = ERR_DATA, resp_err=1.
- Latency: a request accepted at edge N enters a LATENCY-stage delay line. It becomes eligible at edge N+LATENCY-1, so resp_valid rises no earlier than just after edge N+LATENCY-1 (LATENCY=1: visible the cycle after acceptance). Eligible entries wait in a response FIFO of depth MAX_OUTSTANDING.
- Order: responses are returned strictly in acceptance order.
- Holding: while resp_valid=1 && resp_ready=0, resp_data and resp_err stay stable and resp_valid stays high.
- Retire: the FIFO head retires on an edge where resp_valid && resp_ready. The next eligible entry is presented the following cycle with no bubble when one is available.
- outstanding: +1 on accept, -1 on retire, unchanged when both occur on the same edge. It never exceeds MAX_OUTSTANDING or goes below 0.
- Load port: load_en writes array[load_addr] at the edge.
  - The same word accepted for fetch on the same edge returns the old data (read before write).
  - Later accepts see the new data.
  - Loads are ignored while reset_n=0.
- Back-to-back: with resp_ready held at 1 and req_valid held at 1, sustained throughput is one response per cycle once MAX_OUTSTANDING >= LATENCY.
- Reset mid-operation: outstanding responses are dropped and no response is produced for them after release. The first request after release is the first response.

Test Plan:
- LATENCY=1, MAX_OUTSTANDING=1; load words 0..3 = addi x1,5 / addi x2,7 / add x3,x1,x2 / NOP; connect cpu_top; run 30 cycles -> dbg_x3 = 12, no resp_err.
- LATENCY=3, MAX_OUTSTANDING=4; req_valid held high, resp_ready=1, addresses 0,4,8,12 -> first resp_valid 3 cycles after first accept, then data words 0..3 on 4 consecutive cycles, in order.
- MAX_OUTSTANDING=2, resp_ready=0 -> req_ready drops after 2 accepts and outstanding=2. With resp_ready=1 and req_valid both high on one edge -> one retire plus one accept, outstanding stays 2.
- req_addr=32'h2 -> resp_err=1, resp_data=32'h00000013. req_addr=DEPTH_WORDS*4 -> resp_err=1. Next aligned in-range fetch -> resp_err=0.
- load_en with load_addr=5, load_data=32'hDEADBEEF on the same edge as accepting fetch 0x14 -> that response returns the old word 32'h00000013; the next fetch of 0x14 returns 32'hDEADBEEF.
- Assert reset_n=0 asynchronously mid-cycle with 3 outstanding -> resp_valid, req_ready and outstanding go to 0 immediately. After release, a fetch of 0x0 returns word 0 first and no stale response ever appears.
